gauntlet_rom_loader: RTL and testbench

//  Front end of the HPS ROM download path. Consumes the hps_io ioctl byte stream, decodes region,

---
 rtl/gauntlet_loader_pkg.sv | 41 ++++
 rtl/gauntlet_ld_region_dec.sv | 54 +++++
 rtl/gauntlet_rom_loader.sv | 146 ++++++++++++++
 tb/tb_gauntlet_rom_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauntlet_loader_pkg.sv
// gauntlet_loader_pkg: shared types and region map for the Gauntlet ROM loader.
package gauntlet_loader_pkg;

   // Loader sequencing states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_RUN,
      ST_FAIL
   } state_t;

   // Region order matches the o_wr bit positions {cp,ap16r,ap16s,mp10,mp9,mp7,gp}
   typedef enum logic [2:0] {
      RG_GP,
      RG_MP7,
      RG_MP9,
      RG_MP10,
      RG_AP16S,
      RG_AP16R,
      RG_CP,
      RG_NONE
   } region_t;

   // Encoded as log2 of the unit size so it doubles as the byte-to-unit shift
   typedef enum logic [1:0] {
      U_BYTE  = 2'd0,
      U_WORD  = 2'd1,
      U_DWORD = 2'd2
   } unit_t;

   localparam logic [24:0] GP_BASE    = 25'h00000;
   localparam logic [24:0] MP7_BASE   = 25'h40000;
   localparam logic [24:0] MP9_BASE   = 25'h50000;
   localparam logic [24:0] MP10_BASE  = 25'h60000;
   localparam logic [24:0] AP16S_BASE = 25'h68000;
   localparam logic [24:0] AP16R_BASE = 25'h70000;
   localparam logic [24:0] CP_BASE    = 25'h74000;
   localparam logic [24:0] CP_LIMIT   = 25'h76000;

endpackage

// File: rtl/gauntlet_ld_region_dec.sv
// gauntlet_ld_region_dec: byte address -> region strobe, unit width, lane-last flag, local address.
module gauntlet_ld_region_dec
   import gauntlet_loader_pkg::*;
(
   input  logic [24:0] addr,
   output logic [6:0]  onehot,
   output unit_t       unit,
   output logic        lane_last,
   output logic [15:0] local_addr
);

   region_t     region;
   logic [24:0] base;
   logic [24:0] offset;

   // Range decode, then derive unit width, strobe bit and region-local unit address
   always_comb begin
      region = RG_NONE;
      base   = '0;
      if (addr < MP7_BASE) begin
         region = RG_GP;    base = GP_BASE;
      end else if (addr < MP9_BASE) begin
         region = RG_MP7;   base = MP7_BASE;
      end else if (addr < MP10_BASE) begin
         region = RG_MP9;   base = MP9_BASE;
      end else if (addr < AP16S_BASE) begin
         region = RG_MP10;  base = MP10_BASE;
      end else if (addr < AP16R_BASE) begin
         region = RG_AP16S; base = AP16S_BASE;
      end else if (addr < CP_BASE) begin
         region = RG_AP16R; base = AP16R_BASE;
      end else if (addr < CP_LIMIT) begin
         region = RG_CP;    base = CP_BASE;
      end

      case (region)
         RG_GP:                   unit = U_DWORD;
         RG_MP7, RG_MP9, RG_MP10: unit = U_WORD;
         default:                 unit = U_BYTE;
      endcase

      onehot = (region == RG_NONE) ? '0 : (7'd1 << region);

      case (unit)
         U_DWORD: lane_last = (addr[1:0] == 2'b11);
         U_WORD:  lane_last = addr[0];
         default: lane_last = 1'b1;
      endcase

      offset     = addr - base;
      local_addr = 16'(offset >> unit);
   end

endmodule

// File: rtl/gauntlet_rom_loader.sv
// gauntlet_rom_loader: hps_io ioctl front end -- region decode, byte packing, per-region write
// strobes, core reset hold and DIP capture.
// Optional feature: define GAUNTLET_LOADER_CSUM_EN to build the 16-bit image checksum on o_csum.
module gauntlet_rom_loader
   import gauntlet_loader_pkg::*;
#(
   parameter logic [7:0]  ROM_INDEX   = 8'd0,
   parameter logic [7:0]  DIP_INDEX   = 8'd254,
   parameter logic [24:0] ROM_BYTES   = 25'h76000,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [6:0]  o_wr,
   output logic [15:0] o_addr,
   output logic [31:0] o_data,
   output logic        o_core_reset,
   output logic [63:0] o_sw,
   output logic        o_err,
   output logic [15:0] o_csum
);

   state_t      state, state_nxt;
   logic [24:0] exp_addr;
   logic        bad_word;
   logic [23:0] shreg;
   logic [15:0] hold_cnt;

   logic [6:0]  dec_onehot;
   unit_t       dec_unit;
   logic        dec_lane_last;
   logic [15:0] dec_local;

   logic        load_start;
   logic        accept;
   logic        seq_ok;
   logic [31:0] packed_data;

   gauntlet_ld_region_dec u_dec (
      .addr       (ioctl_addr),
      .onehot     (dec_onehot),
      .unit       (dec_unit),
      .lane_last  (dec_lane_last),
      .local_addr (dec_local)
   );

   // Stream qualifiers and the packed word as it would be written on this byte
   always_comb begin
      load_start = ioctl_download && (ioctl_index == ROM_INDEX) && (state != ST_LOAD);
      accept     = ioctl_wr && (ioctl_index == ROM_INDEX) && (state == ST_LOAD)
                   && (ioctl_addr < ROM_BYTES);
      seq_ok     = (ioctl_addr == exp_addr);
      case (dec_unit)
         U_DWORD: packed_data = {shreg, ioctl_dout};
         U_WORD:  packed_data = {16'h0000, shreg[7:0], ioctl_dout};
         default: packed_data = {24'h000000, ioctl_dout};
      endcase
   end

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next state and core reset; a ROM download start restarts the load from any other state
   always_comb begin
      state_nxt    = state;
      o_core_reset = (state != ST_RUN);
      if (load_start) begin
         state_nxt = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD:
               if (!ioctl_download)
                  state_nxt = (exp_addr == ROM_BYTES) ? ST_FLUSH : ST_FAIL;
            ST_FLUSH:
               if (hold_cnt == 16'(HOLD_CYCLES - 1)) state_nxt = ST_RUN;
            default: ;
         endcase
      end
   end

   // Sequencing, packing, registered strobes, error flag, hold counter and DIP capture
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         o_wr     <= '0;
         o_addr   <= '0;
         o_data   <= '0;
         o_err    <= 1'b0;
         o_sw     <= '0;
         exp_addr <= '0;
         bad_word <= 1'b0;
         shreg    <= '0;
         hold_cnt <= '0;
      end else begin
         o_wr <= '0;
         if (load_start) begin
            o_err    <= 1'b0;
            exp_addr <= '0;
            bad_word <= 1'b0;
         end else if (accept) begin
            shreg    <= {shreg[15:0], ioctl_dout};
            exp_addr <= ioctl_addr + 25'd1;
            if (!seq_ok) o_err <= 1'b1;
            // A word that saw any out-of-sequence byte is dropped at its last lane
            if (dec_lane_last) begin
               bad_word <= 1'b0;
               if (seq_ok && !bad_word) begin
                  o_wr   <= dec_onehot;
                  o_addr <= dec_local;
                  o_data <= packed_data;
               end
            end else begin
               bad_word <= bad_word | !seq_ok;
            end
         end

         if ((state == ST_LOAD) && (state_nxt == ST_FAIL)) o_err <= 1'b1;

         // The cycle that detects the end of download counts as the first hold cycle
         if ((state != ST_FLUSH) && (state_nxt == ST_FLUSH)) hold_cnt <= 16'd1;
         else if (state == ST_FLUSH)                         hold_cnt <= hold_cnt + 16'd1;

         if (ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == '0))
            o_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
   end

`ifdef GAUNTLET_LOADER_CSUM_EN
   // Wrapping sum of accepted image bytes; only advances in LOAD so it freezes afterwards
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)        o_csum <= '0;
      else if (load_start) o_csum <= '0;
      else if (accept)     o_csum <= o_csum + {8'h00, ioctl_dout};
   end
`else
   assign o_csum = '0;
`endif

endmodule

// File: tb/tb_gauntlet_rom_loader.sv
// tb_gauntlet_rom_loader: directed stimulus with a strobe scoreboard for gauntlet_rom_loader.
module tb_gauntlet_rom_loader;

   localparam logic [24:0] ROM_END = 25'h76000;

   typedef struct packed {
      logic [6:0]  wr;
      logic [15:0] addr;
      logic [31:0] data;
   } strobe_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [6:0]  o_wr;
   logic [15:0] o_addr;
   logic [31:0] o_data;
   logic        o_core_reset;
   logic [63:0] o_sw;
   logic        o_err;
   logic [15:0] o_csum;

   int          errors = 0;
   int          checks = 0;
   strobe_t     exp_q[$];
   logic [15:0] csum_model = '0;
   logic [15:0] csum_frozen;

   gauntlet_rom_loader #(
      .ROM_INDEX   (8'd0),
      .DIP_INDEX   (8'd254),
      .ROM_BYTES   (25'h76000),
      .HOLD_CYCLES (16)
   ) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .o_wr           (o_wr),
      .o_addr         (o_addr),
      .o_data         (o_data),
      .o_core_reset   (o_core_reset),
      .o_sw           (o_sw),
      .o_err          (o_err),
      .o_csum         (o_csum)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic expect_strobe(input logic [6:0] w, input logic [15:0] a, input logic [31:0] d);
      strobe_t s;
      s.wr   = w;
      s.addr = a;
      s.data = d;
      exp_q.push_back(s);
   endtask

   task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr    = 1'b0;
   endtask

   // ROM byte during a load; the checksum model follows what the image should sum to
   task automatic rom_byte(input logic [24:0] a, input logic [7:0] d);
      if (a < ROM_END) csum_model = csum_model + {8'h00, d};
      wr_byte(8'd0, a, d);
   endtask

   task automatic run_bytes(input logic [24:0] start, input int unsigned n);
      logic [24:0] a;
      for (int unsigned i = 0; i < n; i++) begin
         a = start + 25'(i);
         rom_byte(a, a[7:0]);
      end
   endtask

   task automatic start_load();
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      tick();
      csum_model     = '0;
   endtask

   task automatic check_csum(input string name, input logic [15:0] req);
`ifdef GAUNTLET_LOADER_CSUM_EN
      check(name, o_csum, req);
`else
      check(name, o_csum, 16'h0000);
`endif
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation
   always @(negedge clk_sys) begin
      if (reset_n === 1'b1 && o_wr !== 7'd0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual wr=%b addr=%h data=%h required=no strobe",
                     o_wr, o_addr, o_data);
         end else begin
            check("strobe", {o_wr, o_addr, o_data}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_index    = '0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      repeat (3) tick();
      check("rst_wr",         o_wr, 7'd0);
      check("rst_addr",       o_addr, 16'd0);
      check("rst_data",       o_data, 32'd0);
      check("rst_err",        o_err, 1'b0);
      check("rst_sw",         o_sw, 64'd0);
      check("rst_csum",       o_csum, 16'd0);
      check("rst_core_reset", o_core_reset, 1'b1);
      reset_n = 1'b1;
      tick();

      // Walk every region with resync jumps; the jumped-to word is always dropped
      start_load();
      check("load_core_reset", o_core_reset, 1'b1);
      expect_strobe(7'h01, 16'h0000, 32'h00010203);
      expect_strobe(7'h01, 16'h0001, 32'h04050607);
      run_bytes(25'h00000, 8);
      check("err_clean", o_err, 1'b0);
      run_bytes(25'h3FFFC, 4);
      check("err_jump", o_err, 1'b1);
      expect_strobe(7'h02, 16'h0000, 32'h00000001);
      expect_strobe(7'h02, 16'h0001, 32'h00000203);
      run_bytes(25'h40000, 4);
      expect_strobe(7'h02, 16'h7FFF, 32'h0000FEFF);
      run_bytes(25'h4FFFC, 4);
      expect_strobe(7'h04, 16'h0000, 32'h00000001);
      run_bytes(25'h50000, 2);
      expect_strobe(7'h04, 16'h7FFF, 32'h0000FEFF);
      run_bytes(25'h5FFFC, 4);
      expect_strobe(7'h08, 16'h0000, 32'h00000001);
      run_bytes(25'h60000, 2);
      expect_strobe(7'h08, 16'h3FFF, 32'h0000FEFF);
      run_bytes(25'h67FFC, 4);
      expect_strobe(7'h10, 16'h0000, 32'h00000000);
      expect_strobe(7'h10, 16'h0001, 32'h00000001);
      run_bytes(25'h68000, 2);
      expect_strobe(7'h10, 16'h7FFF, 32'h000000FF);
      run_bytes(25'h6FFFE, 2);
      expect_strobe(7'h20, 16'h0000, 32'h00000000);
      run_bytes(25'h70000, 1);
      expect_strobe(7'h20, 16'h3FFF, 32'h000000FF);
      run_bytes(25'h73FFE, 2);
      expect_strobe(7'h40, 16'h0000, 32'h00000000);
      run_bytes(25'h74000, 1);
      expect_strobe(7'h40, 16'h1FFD, 32'h000000FD);
      expect_strobe(7'h40, 16'h1FFE, 32'h000000FE);
      expect_strobe(7'h40, 16'h1FFF, 32'h000000FF);
      run_bytes(25'h75FFC, 4);
      rom_byte(25'h76000, 8'h55);
      tick();
      check("queue_after_image", exp_q.size(), 0);

      // End of image: reset held for the hold window, then released
      ioctl_download = 1'b0;
      n = 0;
      while (o_core_reset === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("hold_cycles", n, 16);
      check("run_core_reset", o_core_reset, 1'b0);
      check("err_sticky", o_err, 1'b1);
      check_csum("csum_image", csum_model);
      csum_frozen = csum_model;

      // DIP capture while running; ROM-index writes outside LOAD are ignored
      ioctl_index    = 8'd254;
      ioctl_download = 1'b1;
      tick();
      wr_byte(8'd254, 25'h3, 8'hA5);
      wr_byte(8'd254, 25'h0, 8'h3C);
      wr_byte(8'd254, 25'h8, 8'h77);
      wr_byte(8'd7,   25'h1, 8'h99);
      ioctl_download = 1'b0;
      wr_byte(8'd0,   25'h3, 8'h11);
      tick();
      check("dip_sw", o_sw, 64'h00000000_A500003C);
      check("dip_core_reset", o_core_reset, 1'b0);
      check_csum("csum_frozen", csum_frozen);

      // Skipped byte drops its dword, then a short image fails
      start_load();
      check("reload_err_clear", o_err, 1'b0);
      check("reload_core_reset", o_core_reset, 1'b1);
      check("reload_csum_clear", o_csum, 16'd0);
      expect_strobe(7'h01, 16'h0000, 32'h00010203);
      run_bytes(25'h00000, 6);
      rom_byte(25'h00007, 8'h07);
      check("skip_err", o_err, 1'b1);
      expect_strobe(7'h01, 16'h0002, 32'h08090A0B);
      run_bytes(25'h00008, 4);
      expect_strobe(7'h02, 16'h7FFF, 32'h0000FEFF);
      run_bytes(25'h4FFFC, 4);
      ioctl_download = 1'b0;
      n = 0;
      repeat (20) begin
         tick();
         if (o_core_reset === 1'b1) n++;
      end
      check("fail_core_reset", n, 20);
      check("fail_err", o_err, 1'b1);
      check_csum("csum_fail_frozen", csum_model);

      // Clean short image: out-of-range byte is silent, short length alone raises the error
      start_load();
      check("reload2_err_clear", o_err, 1'b0);
      expect_strobe(7'h01, 16'h0000, 32'h00010203);
      run_bytes(25'h00000, 4);
      rom_byte(25'h76000, 8'h55);
      tick();
      check("oob_no_err", o_err, 1'b0);
      ioctl_download = 1'b0;
      tick();
      tick();
      check("short_err", o_err, 1'b1);
      check("short_core_reset", o_core_reset, 1'b1);

      // Reset in the middle of a load
      start_load();
      run_bytes(25'h00000, 2);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_core_reset", o_core_reset, 1'b1);
      check("midrst_err", o_err, 1'b0);
      check("midrst_sw", o_sw, 64'd0);
      check("midrst_csum", o_csum, 16'd0);
      check("midrst_wr", o_wr, 7'd0);
      ioctl_download = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("idle_core_reset", o_core_reset, 1'b1);
      start_load();
      expect_strobe(7'h01, 16'h0000, 32'h20212223);
      rom_byte(25'h0, 8'h20);
      rom_byte(25'h1, 8'h21);
      rom_byte(25'h2, 8'h22);
      rom_byte(25'h3, 8'h23);
      tick();
      tick();
      check("after_rst_err", o_err, 1'b0);
      check_csum("after_rst_csum", csum_model);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
